// File: rtl/rc4_session_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_session_arbiter
//  Description : Shares one RC4 keystream core between two clients (A = 0,
//                B = 1) one session at a time. A session grants a client,
//                loads its key, waits for key scheduling, then XORs each
//                character with exactly one prefetched keystream word and
//                emits the result on a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_session_arbiter #(
    parameter int N            = 7,
    parameter int INIT_TIMEOUT = 1023,
    parameter int TW           = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [N-1:0] key_a,
    input  logic [N-1:0] key_b,
    output logic [1:0]   grant,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         out_owner,
    input  logic         out_ready,
    output logic         core_rst,
    output logic [N-1:0] core_key,
    input  logic         core_init_done,
    output logic         core_ks_req,
    input  logic         core_ks_valid,
    input  logic [N-1:0] core_ks,
    output logic         err
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOAD   = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_STREAM = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    // Counter value on the last permitted WAIT_INIT cycle.
    localparam logic [TW-1:0] c_TMO_LAST = TW'(INIT_TIMEOUT - 1);

    logic [2:0]    r_state;
    logic [1:0]    r_grant;
    logic          r_owner;
    logic          r_last;
    logic [N-1:0]  r_key;
    logic [TW-1:0] r_tcnt;
    logic [N-1:0]  r_ks_buf;
    logic          r_ks_full;
    logic          r_ks_pending;
    logic          r_out_valid;
    logic [N-1:0]  r_out_data;
    logic          r_out_last;
    logic          r_out_owner;
    logic          r_core_rst;
    logic          r_core_ks_req;
    logic          r_err;

    logic          w_owner_req;
    logic          w_pick_b;
    logic          w_in_ready;
    logic          w_xfer;

    // Session owner still asking for the core; dropping it aborts the session.
    assign w_owner_req = |(req & r_grant);
    // B wins when it is the only requester, or on a tie when A went last.
    assign w_pick_b    = (req == 2'b10) || ((req == 2'b11) && !r_last);
    assign w_in_ready  = (r_state == c_ST_STREAM) && w_owner_req && r_ks_full &&
                         (!r_out_valid || out_ready);
    assign w_xfer      = in_valid && w_in_ready;

    assign grant       = r_grant;
    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_last    = r_out_last;
    assign out_owner   = r_out_owner;
    assign core_rst    = r_core_rst;
    assign core_key    = r_key;
    assign core_ks_req = r_core_ks_req;
    assign err         = r_err;

    // Session state machine, keystream prefetch buffer and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_grant       <= 2'b00;
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_key         <= '0;
            r_tcnt        <= '0;
            r_ks_buf      <= '0;
            r_ks_full     <= 1'b0;
            r_ks_pending  <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_out_owner   <= 1'b0;
            r_core_rst    <= 1'b0;
            r_core_ks_req <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_core_rst    <= 1'b0;
            r_core_ks_req <= 1'b0;
            r_err         <= 1'b0;

            // A new character refills the output register; otherwise a
            // downstream accept empties it.
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data ^ r_ks_buf;
                r_out_last  <= in_last;
                r_out_owner <= r_owner;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (req != 2'b00) begin
                        r_grant    <= w_pick_b ? 2'b10 : 2'b01;
                        r_owner    <= w_pick_b;
                        r_key      <= w_pick_b ? key_b : key_a;
                        r_core_rst <= 1'b1;
                        r_state    <= c_ST_LOAD;
                    end
                end

                c_ST_LOAD: begin
                    r_tcnt  <= '0;
                    r_state <= c_ST_WAIT;
                end

                c_ST_WAIT: begin
                    if (!w_owner_req) begin
                        r_state <= c_ST_DRAIN;
                    end else if (core_init_done) begin
                        r_state <= c_ST_STREAM;
                    end else if (r_tcnt == c_TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end

                c_ST_STREAM: begin
                    if (!w_owner_req) begin
                        // Abort: drop the buffered word; a word still in
                        // flight is absorbed in DRAIN.
                        r_ks_full <= 1'b0;
                        if (core_ks_valid && r_ks_pending) begin
                            r_ks_pending <= 1'b0;
                        end
                        r_state <= c_ST_DRAIN;
                    end else begin
                        if (w_xfer) begin
                            r_ks_full <= 1'b0;
                            if (in_last) begin
                                r_state <= c_ST_DRAIN;
                            end
                        end
                        // Pending and full are never both set, so a fill
                        // cannot coincide with a transfer.
                        if (core_ks_valid && r_ks_pending) begin
                            r_ks_buf     <= core_ks;
                            r_ks_full    <= 1'b1;
                            r_ks_pending <= 1'b0;
                        end else if ((!r_ks_full || w_xfer) && !r_ks_pending &&
                                     !(w_xfer && in_last)) begin
                            // Fetch the next word as soon as the buffer is
                            // free, including the cycle it is being consumed.
                            r_core_ks_req <= 1'b1;
                            r_ks_pending  <= 1'b1;
                        end
                    end
                end

                c_ST_DRAIN: begin
                    if (core_ks_valid && r_ks_pending) begin
                        r_ks_pending <= 1'b0;
                    end
                    if (!r_out_valid && !r_ks_pending) begin
                        r_state <= c_ST_DONE;
                    end
                end

                c_ST_DONE: begin
                    r_last  <= r_owner;
                    r_grant <= 2'b00;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc4_session_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc4_session_arbiter
//  Description : Self-checking bench for rc4_session_arbiter with an RC4 core
//                stub, a keystream/character scoreboard and directed sessions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_session_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [6:0] key_a, key_b;
    logic [1:0] grant;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [6:0] out_data;
    logic       out_last;
    logic       out_owner;
    logic       out_ready;
    logic       core_rst;
    logic [6:0] core_key;
    logic       core_init_done = 1'b0;
    logic       core_ks_req;
    logic       core_ks_valid  = 1'b0;
    logic [6:0] core_ks        = 7'h00;
    logic       err;

    always #5 clk = ~clk;

    rc4_session_arbiter #(.N(7), .INIT_TIMEOUT(8), .TW(4)) dut (
        .clk(clk), .rst(rst), .req(req), .key_a(key_a), .key_b(key_b),
        .grant(grant), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_owner(out_owner), .out_ready(out_ready),
        .core_rst(core_rst), .core_key(core_key), .core_init_done(core_init_done),
        .core_ks_req(core_ks_req), .core_ks_valid(core_ks_valid), .core_ks(core_ks),
        .err(err)
    );

    typedef struct packed {
        logic [6:0] d;
        logic       l;
        logic       o;
    } exp_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    exp_t       exp_q[$];
    logic [6:0] mdl_ks[$];
    logic [6:0] ks_src[$];
    logic [6:0] tx_q[$];
    logic [6:0] out_log[$];
    logic       last_log[$];
    exp_t       e;
    logic [6:0] w_word;
    logic [6:0] gen_word   = 7'h2B;
    logic       exp_owner  = 1'b0;
    bit         never_init = 1'b0;
    bit         saw_ready  = 1'b0;
    int         ks_lat     = 1;
    int         init_cnt   = 0;
    int         ks_cnt     = 0;
    int         cyc        = 0;
    int         rst_cyc    = 0;
    int         err_cyc    = 0;
    int         err_cnt    = 0;
    int         ks_req_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard, event monitors and RC4 core stub, all evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            mdl_ks.delete();
            core_ks_valid  = 1'b0;
            core_init_done = 1'b0;
            init_cnt       = 0;
            ks_cnt         = 0;
        end else begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_data",  out_data,  exp_q[0].d);
                chk("out_last",  out_last,  exp_q[0].l);
                chk("out_owner", out_owner, exp_q[0].o);
                if (out_ready) begin
                    out_log.push_back(out_data);
                    last_log.push_back(out_last);
                    void'(exp_q.pop_front());
                end
            end
            if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                chk("ks_word_available", mdl_ks.size() != 0, 1);
                if (mdl_ks.size() != 0) begin
                    w_word = mdl_ks.pop_front();
                    e.d = in_data ^ w_word;
                    e.l = in_last;
                    e.o = exp_owner;
                    exp_q.push_back(e);
                end
            end
            if (core_rst) rst_cyc = cyc;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (core_ks_req) ks_req_cnt++;
            if (in_ready) saw_ready = 1'b1;

            // Core stub: init_done 5 cycles after core_rst, words ks_lat
            // cycles after each request.
            if (core_ks_valid) core_ks_valid = 1'b0;
            if (core_rst) begin
                init_cnt       = 5;
                core_init_done = 1'b0;
                ks_cnt         = 0;
                mdl_ks.delete();
            end else if (init_cnt > 0) begin
                init_cnt--;
                if (init_cnt == 0 && !never_init) core_init_done = 1'b1;
            end
            if (ks_cnt > 0) begin
                ks_cnt--;
                if (ks_cnt == 0) begin
                    if (ks_src.size() != 0) begin
                        w_word = ks_src.pop_front();
                    end else begin
                        w_word   = gen_word;
                        gen_word = gen_word + 7'd5;
                    end
                    core_ks       = w_word;
                    core_ks_valid = 1'b1;
                    mdl_ks.push_back(w_word);
                end
            end
            if (core_ks_req) ks_cnt = ks_lat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [1:0] g, input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (grant == g) break;
        end
        chk(name, grant, g);
        tick();
    endtask

    task automatic send(input logic [6:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", ok, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_all();
        foreach (tx_q[i]) send(tx_q[i], i == tx_q.size() - 1);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; req = 2'b00; key_a = '0; key_b = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0); chk("rst_out_last", out_last, 0);
        chk("rst_core_rst", core_rst, 0);  chk("rst_ks_req", core_ks_req, 0);
        chk("rst_err", err, 0);            chk("rst_out_data", out_data, 0);
        chk("rst_core_key", core_key, 0);  chk("rst_out_owner", out_owner, 0);
        tick();
        rst = 1'b0;

        // Single A session with known keystream.
        ks_src = '{7'h15, 7'h33, 7'h7F};
        key_a = 7'h2A; key_b = 7'h55; exp_owner = 1'b0; ks_req_cnt = 0;
        out_log.delete(); last_log.delete();
        req = 2'b01;
        wait_grant(2'b01, "t1_grant_a");
        chk("t1_core_key", core_key, 7'h2A);
        key_a = 7'h00;
        tx_q = '{7'h41, 7'h42, 7'h43};
        send_all();
        chk("t1_key_held", core_key, 7'h2A);
        req = 2'b00;
        wait_grant(2'b00, "t1_release");
        chk("t1_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("t1_out0", out_log[0], 7'h54);  chk("t1_out1", out_log[1], 7'h71);
            chk("t1_out2", out_log[2], 7'h3C);  chk("t1_last0", last_log[0], 0);
            chk("t1_last1", last_log[1], 0);    chk("t1_last2", last_log[2], 1);
        end
        chk("t1_ks_reqs", ks_req_cnt, 3);

        // Tie from reset goes to A, then B, then B again alone.
        rst = 1'b1; tick(); rst = 1'b0;
        key_a = 7'h11; key_b = 7'h5C; exp_owner = 1'b0;
        req = 2'b11;
        wait_grant(2'b01, "t2_tie_a_first");
        chk("t2_key_a", core_key, 7'h11);
        tx_q = '{7'h22};
        send_all();
        req = 2'b10; exp_owner = 1'b1;
        wait_grant(2'b10, "t2_then_b");
        chk("t2_key_b", core_key, 7'h5C);
        tx_q = '{7'h30, 7'h31};
        send_all();
        req = 2'b00;
        wait_grant(2'b00, "t2_b_release");
        req = 2'b10;
        wait_grant(2'b10, "t2_b_again");
        chk("t2_key_b_again", core_key, 7'h5C);
        tx_q = '{7'h7E};
        send_all();
        req = 2'b00;
        wait_grant(2'b00, "t2_release");

        // Backpressure: output held, no keystream word lost or reused.
        ks_src = '{7'h01, 7'h02, 7'h04, 7'h08};
        key_a = 7'h03; exp_owner = 1'b0; ks_req_cnt = 0;
        out_log.delete(); last_log.delete();
        req = 2'b01;
        wait_grant(2'b01, "t3_grant");
        send(7'h10, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h20; in_last = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3_hold_ready", in_ready, 0);
            chk("t3_hold_data", out_data, 7'h11);
            chk("t3_hold_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        send(7'h20, 1'b0);
        send(7'h40, 1'b0);
        send(7'h7F, 1'b1);
        req = 2'b00;
        wait_grant(2'b00, "t3_release");
        chk("t3_count", out_log.size(), 4);
        if (out_log.size() == 4) begin
            chk("t3_out0", out_log[0], 7'h11); chk("t3_out1", out_log[1], 7'h22);
            chk("t3_out2", out_log[2], 7'h44); chk("t3_out3", out_log[3], 7'h77);
        end
        chk("t3_ks_words", (ks_req_cnt >= 4) && (ks_req_cnt <= 5), 1);

        // Init timeout: err once, 9 cycles after LOAD, grant clears.
        never_init = 1'b1; err_cnt = 0; saw_ready = 1'b0;
        req = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err) begin
                found = 1'b1;
                break;
            end
        end
        chk("t4_err_seen", found, 1);
        tick();
        req = 2'b00;
        @(negedge clk);
        chk("t4_grant_clear", grant, 0);
        repeat (5) tick();
        chk("t4_err_once", err_cnt, 1);
        chk("t4_err_delay", err_cyc - rst_cyc, 9);
        chk("t4_no_ready", saw_ready, 0);
        never_init = 1'b0;

        // Abort with a keystream word in flight; next session uses fresh words.
        ks_lat = 3; ks_src = '{7'h66, 7'h0F, 7'h21}; ks_req_cnt = 0; exp_owner = 1'b0;
        req = 2'b01;
        wait_grant(2'b01, "t5_grant");
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (core_ks_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_req_seen", found, 1);
        tick();
        req = 2'b00;
        wait_grant(2'b00, "t5_abort_release");
        chk("t5_one_req", ks_req_cnt, 1);
        chk("t5_word_absorbed", ks_src.size(), 2);
        ks_lat = 1; out_log.delete(); last_log.delete();
        req = 2'b01;
        wait_grant(2'b01, "t5_regrant");
        tx_q = '{7'h70, 7'h01};
        send_all();
        req = 2'b00;
        wait_grant(2'b00, "t5_release");
        chk("t5_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("t5_out0", out_log[0], 7'h7F);
            chk("t5_out1", out_log[1], 7'h20);
        end

        // Reset while an output is waiting, then a normal session.
        ks_src = '{7'h05, 7'h0A}; out_ready = 1'b0; exp_owner = 1'b0;
        req = 2'b01;
        wait_grant(2'b01, "t6_grant");
        send(7'h50, 1'b0);
        @(negedge clk);
        chk("t6_pre_valid", out_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ks_src = '{7'h33, 7'h44};
        @(negedge clk);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_ready", in_ready, 0);
        chk("t6_rst_no_pulse", core_rst, 0);
        tick();
        out_ready = 1'b1; out_log.delete(); last_log.delete();
        wait_grant(2'b01, "t6_regrant");
        tx_q = '{7'h11, 7'h22};
        send_all();
        req = 2'b00;
        wait_grant(2'b00, "t6_release");
        chk("t6_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("t6_out0", out_log[0], 7'h22);
            chk("t6_out1", out_log[1], 7'h66);
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
